// File: rtl/cpu_program_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : cpu_program_sequencer
//  Purpose  : Loads a small instruction store and replays it into the cpu
//             over the in/load/s + w handshake, capturing result and flags.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_program_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [15:0]       prog_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              go,
    output logic [15:0]       cpu_in,
    output logic              cpu_load,
    output logic              cpu_s,
    input  logic [15:0]       cpu_out,
    input  logic              cpu_N,
    input  logic              cpu_V,
    input  logic              cpu_Z,
    input  logic              cpu_w,
    output logic [15:0]       result,
    output logic              res_N,
    output logic              res_V,
    output logic              res_Z,
    output logic              res_valid,
    output logic [ADDR_W:0]   pc,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int         c_DEPTH       = 2**ADDR_W;
    localparam logic [3:0] c_S_IDLE      = 4'd0;
    localparam logic [3:0] c_S_WAIT_W    = 4'd1;
    localparam logic [3:0] c_S_LOAD      = 4'd2;
    localparam logic [3:0] c_S_START     = 4'd3;
    localparam logic [3:0] c_S_WAIT_BUSY = 4'd4;
    localparam logic [3:0] c_S_WAIT_DONE = 4'd5;
    localparam logic [3:0] c_S_CAPTURE   = 4'd6;
    localparam logic [3:0] c_S_DONE      = 4'd7;
    localparam logic [3:0] c_S_ERROR     = 4'd8;

    logic [15:0]     r_mem [c_DEPTH];
    logic [3:0]      r_state;
    logic [3:0]      w_next;
    logic [ADDR_W:0] r_pc;
    logic [ADDR_W:0] r_len;
    logic [ADDR_W:0] w_pc_inc;
    logic [7:0]      r_wait_cnt;
    logic            w_timeout;
    logic            w_in_wait;
    logic            w_next_busy;
    logic            w_can_start;
    logic [15:0]     r_result;
    logic            r_res_N;
    logic            r_res_V;
    logic            r_res_Z;
    logic            r_res_valid;
    logic            r_busy;
    logic            r_done;
    logic            r_error;
    logic            r_cpu_load;
    logic            r_cpu_s;

    assign w_pc_inc    = r_pc + 1'b1;
    assign w_timeout   = (r_wait_cnt == 8'(TIMEOUT - 1));
    assign w_in_wait   = (r_state == c_S_WAIT_W) || (r_state == c_S_WAIT_BUSY) ||
                         (r_state == c_S_WAIT_DONE);
    assign w_can_start = (r_state == c_S_IDLE) || (r_state == c_S_DONE) ||
                         (r_state == c_S_ERROR);
    assign w_next_busy = (w_next != c_S_IDLE) && (w_next != c_S_DONE) &&
                         (w_next != c_S_ERROR);

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE, c_S_DONE, c_S_ERROR: begin
                if (go) w_next = (prog_len == '0) ? c_S_DONE : c_S_WAIT_W;
            end
            c_S_WAIT_W: begin
                if (cpu_w)          w_next = c_S_LOAD;
                else if (w_timeout) w_next = c_S_ERROR;
            end
            c_S_LOAD:  w_next = c_S_START;
            c_S_START: w_next = c_S_WAIT_BUSY;
            c_S_WAIT_BUSY: begin
                if (!cpu_w)         w_next = c_S_WAIT_DONE;
                else if (w_timeout) w_next = c_S_ERROR;
            end
            c_S_WAIT_DONE: begin
                if (cpu_w)          w_next = c_S_CAPTURE;
                else if (w_timeout) w_next = c_S_ERROR;
            end
            c_S_CAPTURE: w_next = (w_pc_inc == r_len) ? c_S_DONE : c_S_WAIT_W;
            default:     w_next = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_pc        <= '0;
            r_len       <= '0;
            r_wait_cnt  <= '0;
            r_result    <= '0;
            r_res_N     <= 1'b0;
            r_res_V     <= 1'b0;
            r_res_Z     <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cpu_load  <= 1'b0;
            r_cpu_s     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_busy      <= w_next_busy;
            r_done      <= (w_next == c_S_DONE);
            r_error     <= (w_next == c_S_ERROR);
            r_cpu_load  <= (w_next == c_S_LOAD);
            r_cpu_s     <= (w_next == c_S_START);
            r_res_valid <= (r_state == c_S_CAPTURE);

            // Wait counter restarts on every state change, so each wait state gets its own budget.
            if (w_next != r_state)
                r_wait_cnt <= '0;
            else if (w_in_wait)
                r_wait_cnt <= r_wait_cnt + 8'd1;

            if (w_can_start && go) begin
                r_len <= prog_len;
                r_pc  <= '0;
            end

            if (r_state == c_S_CAPTURE) begin
                r_result <= cpu_out;
                r_res_N  <= cpu_N;
                r_res_V  <= cpu_V;
                r_res_Z  <= cpu_Z;
                r_pc     <= w_pc_inc;
            end
        end
    end

    // The store has no reset: programs survive a sequencer reset.
    always_ff @(posedge clk) begin
        if (prog_we && !r_busy)
            r_mem[prog_addr] <= prog_data;
    end

    assign cpu_in    = r_busy ? r_mem[r_pc[ADDR_W-1:0]] : 16'h0000;
    assign cpu_load  = r_cpu_load;
    assign cpu_s     = r_cpu_s;
    assign result    = r_result;
    assign res_N     = r_res_N;
    assign res_V     = r_res_V;
    assign res_Z     = r_res_Z;
    assign res_valid = r_res_valid;
    assign pc        = r_pc;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;

endmodule
`default_nettype wire

// File: doc/cpu_program_sequencer.md
Name: cpu_program_sequencer

Overview:
Bus-master counterpart to the cpu block. It owns the cpu's instruction-side handshake (in/load/s) and consumes its result side (out/N/V/Z/w). A small instruction store is filled through a program port. On go, each stored instruction is issued to the cpu using the wait-flag handshake, and the cpu result and flags are captured after every instruction. Used as the on-board/bench driver that replaces hand-toggled switches and keys.

Parameters:
ADDR_W, 4, instruction store address width; depth = 2**ADDR_W words.
TIMEOUT, 255, maximum cycles spent in any wait state before error; counter width 8.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
prog_we  input  1  write enable for the instruction store
prog_addr  input  ADDR_W  store write address
prog_data  input  16  instruction word to write
prog_len  input  ADDR_W+1  number of instructions to run (0..2**ADDR_W), sampled on go
go  input  1  start-run pulse
cpu_in  output  16  instruction to cpu
cpu_load  output  1  instruction-register load strobe to cpu
cpu_s  output  1  start strobe to cpu
cpu_out  input  16  cpu datapath result
cpu_N  input  1  cpu negative flag
cpu_V  input  1  cpu overflow flag
cpu_Z  input  1  cpu zero flag
cpu_w  input  1  cpu waiting/idle flag
result  output  16  captured cpu_out of last completed instruction
res_N  output  1  captured N
res_V  output  1  captured V
res_Z  output  1  captured Z
res_valid  output  1  one-cycle pulse when result/flags update
pc  output  ADDR_W+1  index of instruction currently or next issued
busy  output  1  high in every state except IDLE, DONE, ERROR
done  output  1  high in DONE until next go or reset
error  output  1  high in ERROR until next go or reset

Behaviour:
- Reset (synchronous): state IDLE; pc=0; result=0; res_N/V/Z=0; res_valid=0; cpu_in=0; cpu_load=0; cpu_s=0; busy=0; done=0; error=0. Instruction store is NOT cleared.
- Store: write mem[prog_addr]=prog_data on a clk edge when prog_we=1 and busy=0; ignored while busy=1.
- States: IDLE, WAIT_W, LOAD, START, WAIT_BUSY, WAIT_DONE, CAPTURE, DONE, ERROR.
- IDLE/DONE/ERROR + go: latch len=prog_len; pc=0; clear done and error; go to WAIT_W, or directly to DONE if len=0.
- go while busy=1 is ignored.
- WAIT_W: when cpu_w=1 -> LOAD.
- LOAD: cpu_load=1 and cpu_in=mem[pc] for exactly one cycle -> START.
- START: cpu_s=1 for exactly one cycle with cpu_in held -> WAIT_BUSY.
- WAIT_BUSY: when cpu_w=0 -> WAIT_DONE.
- WAIT_DONE: when cpu_w=1 -> CAPTURE.
- CAPTURE (one cycle):
  - register result=cpu_out and res_N/V/Z=cpu_N/V/Z; res_valid=1 in the following cycle only.
  - pc=pc+1; if the new pc equals len -> DONE, else -> WAIT_W.
- cpu_in = mem[pc] in every busy state, 0 otherwise. cpu_load and cpu_s are never high in the same cycle.
- Timeout: an 8-bit wait counter clears on every state change and increments each cycle spent in WAIT_W, WAIT_BUSY or WAIT_DONE. When it reaches TIMEOUT -> ERROR. pc freezes at the failing index; result registers hold their last values.
- Minimum per-instruction latency: 6 cycles (WAIT_W, LOAD, START, WAIT_BUSY, WAIT_DONE, CAPTURE), plus the cpu execution time.
- Reset asserted mid-run wins over all transitions: sequencer goes to IDLE with outputs as above; an in-flight cpu instruction is abandoned.
- pc does not wrap: len = 2**ADDR_W runs the full store and finishes with pc = 2**ADDR_W.

Test Plan:
- Program run: write mem[0]=0xD007 (MOV R0,#7), mem[1]=0xD102 (MOV R1,#2), mem[2]=0xA148 (ADD R2,R1,R0 LSL#1); prog_len=3; pulse go with the real cpu -> three res_valid pulses, final result=0x0010, res_N=0, done=1, pc=3, error=0.
- Flags: mem[0]=0xD005, mem[1]=0xA800 (CMP R0,R0); len=2 -> final res_Z=1, res_N=0, res_V=0.
- Protocol check: every instruction shows cpu_load for exactly 1 cycle followed immediately by cpu_s for exactly 1 cycle, with cpu_in stable across both, and cpu_load only asserted while cpu_w=1.
- Zero length: prog_len=0, go -> done=1 one cycle later; cpu_load and cpu_s never assert.
- Timeout: cpu stub holds cpu_w=1 after s; TIMEOUT=255 -> error=1 after 255 cycles in WAIT_BUSY, pc=0, busy=0; go then restarts cleanly.
- Reset and program-port guard: reset pulsed while in WAIT_DONE -> next cycle all outputs zero, state IDLE. prog_we asserted while busy -> store contents unchanged (verified by rerun).
